// File: rtl/teclado_cursor.sv
// Button front-end for the VGA calculator: synchronise and debounce five buttons,
// steer a cursor over a 4x4 keypad and edit a 10-digit nibble display buffer.
module teclado_cursor #(
    parameter int         DEB_CYCLES = 250000,
    parameter logic [3:0] BLANK      = 4'hF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic        BTN_LEFT,
    input  logic        BTN_RIGHT,
    input  logic        BTN_SEL,
    output logic [4:0]  POS,
    output logic [39:0] numeros,
    output logic        CMD_VALID,
    output logic [1:0]  CMD,
    output logic [3:0]  DIG_COUNT
);

    localparam int              CW        = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(DEB_CYCLES - 1);
    localparam logic [39:0]     ALL_BLANK = {10{BLANK}};

    // Button bit order: 4 SEL, 3 UP, 2 DOWN, 1 LEFT, 0 RIGHT (also the priority order)
    logic [4:0]    raw;
    logic [4:0]    sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
    logic [CW-1:0] cnt_q [5];

    assign raw = {BTN_SEL, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    logic [3:0]  pos_q;
    logic [39:0] num_q;
    logic [3:0]  dig_q;
    logic        fresh_q;
    logic        cmd_valid_q;
    logic [1:0]  cmd_q;
    logic [1:0]  row, col;

    assign row = pos_q[3:2];
    assign col = pos_q[1:0];

    // FRESH marks that the buffer still shows the operand just handed to the
    // arithmetic stage; the next digit starts a new number instead of appending.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pos_q       <= '0;
            num_q       <= ALL_BLANK;
            dig_q       <= '0;
            fresh_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (press_q[4]) begin
                if (pos_q <= 4'd9) begin
                    if (fresh_q) begin
                        num_q   <= {{9{BLANK}}, pos_q};
                        dig_q   <= 4'd1;
                        fresh_q <= 1'b0;
                    end else if (dig_q < 4'd10) begin
                        num_q <= {num_q[35:0], pos_q};
                        dig_q <= dig_q + 4'd1;
                    end
                end else if (pos_q <= 4'd13) begin
                    cmd_valid_q <= 1'b1;
                    cmd_q       <= pos_q[1:0] - 2'd2;
                    fresh_q     <= 1'b1;
                end else if (pos_q == 4'd14) begin
                    num_q   <= ALL_BLANK;
                    dig_q   <= '0;
                    fresh_q <= 1'b0;
                end else if (!fresh_q && dig_q != 4'd0) begin
                    num_q <= {BLANK, num_q[39:4]};
                    dig_q <= dig_q - 4'd1;
                end
            end else if (press_q[3]) begin
                pos_q <= {row - 2'd1, col};
            end else if (press_q[2]) begin
                pos_q <= {row + 2'd1, col};
            end else if (press_q[1]) begin
                pos_q <= {row, col - 2'd1};
            end else if (press_q[0]) begin
                pos_q <= {row, col + 2'd1};
            end
        end
    end

    assign POS       = {1'b0, pos_q};
    assign numeros   = num_q;
    assign CMD_VALID = cmd_valid_q;
    assign CMD       = cmd_q;
    assign DIG_COUNT = dig_q;

endmodule

// File: doc/teclado_cursor.md
Name: teclado_cursor

Overview:
- Front-end input controller for the VGA calculator; drives the POS and numeros inputs of the screen stage directly.
- Synchronises and debounces five raw push-buttons and moves a cursor over a 4x4 on-screen keypad.
- On SELECT, digit keys shift into a 10-digit display buffer; operator, clear and delete keys edit the buffer or emit a command pulse for the arithmetic stage.

Parameters:
DEB_CYCLES, 250000, consecutive stable clock cycles required to accept a button level change (10 ms at 25 MHz)
BLANK, 4'hF, nibble code rendered as an empty digit cell

Ports:
CLK  input  1  system clock (25 MHz pixel clock domain)
RESET  input  1  asynchronous, active-low reset
BTN_UP  input  1  raw button, active-high, asynchronous to CLK
BTN_DOWN  input  1  raw button, active-high
BTN_LEFT  input  1  raw button, active-high
BTN_RIGHT  input  1  raw button, active-high
BTN_SEL  input  1  raw button, active-high
POS  output  5  cursor key index 0..15 (POS[4] always 0)
numeros  output  40  display buffer, 10 nibbles; [3:0] is the rightmost / least-significant digit
CMD_VALID  output  1  one-cycle pulse when an operator key is selected
CMD  output  2  operator: 0 '+', 1 '-', 2 '*', 3 '='; valid with CMD_VALID
DIG_COUNT  output  4  digits currently in the buffer, 0..10

Behaviour:
- Reset (RESET=0, asynchronous): POS=0, numeros=all BLANK (40'hFFFFFFFFFF), CMD_VALID=0, CMD=0, DIG_COUNT=0, FRESH=0. All synchronisers, debounce counters and debounced levels cleared to 0. Reset mid-debounce or mid-edit discards everything.
- Per button:
  - 2-FF synchroniser, then debounce counter.
  - The counter increments while the synchronised level differs from the debounced level and clears when they match.
  - When the counter reaches DEB_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
  - Rising edge of the debounced level gives a one-cycle press pulse. Releases produce no action.
- Arbitration: one action per cycle, priority SEL > UP > DOWN > LEFT > RIGHT. Lower-priority pulses in the same cycle are dropped, not queued.
- Cursor: keypad is 4 columns x 4 rows, POS = row*4 + col.
  - UP/DOWN change row mod 4; LEFT/RIGHT change col mod 4 (wrap, e.g. POS 3 + RIGHT -> 0, POS 1 + UP -> 13).
  - The cursor moves only in response to these four buttons.
- Key map (key code = POS): 0-9 digits, 10 '+', 11 '-', 12 '*', 13 '=', 14 CLR, 15 DEL.
- SELECT on digit d:
  - If FRESH=1: numeros = {9xBLANK, d}, DIG_COUNT=1, FRESH=0.
  - Else if DIG_COUNT<10: numeros = {numeros[35:0], d}, DIG_COUNT+1.
  - Else (full): ignored, no change.
- SELECT on 10-13:
  - CMD_VALID=1 for exactly one cycle, CMD = POS-10.
  - numeros is held unchanged so the downstream stage can latch it; FRESH=1.
- SELECT on CLR: numeros = all BLANK, DIG_COUNT=0, FRESH=0.
- SELECT on DEL:
  - If FRESH=0 and DIG_COUNT>0: numeros = {BLANK, numeros[39:4]}, DIG_COUNT-1.
  - Else: ignored (empty buffer, or result still displayed).
- Latency: all outputs are registered and update on the clock edge after the press pulse. Total delay from a clean raw edge to the output change is 2 (sync) + DEB_CYCLES + 2 cycles.
- CMD_VALID is never high on two consecutive cycles, because press pulses are single-cycle and a release is required between presses.
- FRESH is internal state only.

Test Plan (DEB_CYCLES=4):
- Reset release, no buttons -> POS=0, numeros=40'hFFFFFFFFFF, DIG_COUNT=0, CMD_VALID=0 indefinitely.
- Glitch: BTN_RIGHT high 3 cycles then low -> POS stays 0. Held 20 cycles -> POS=1 exactly once, appearing 8 cycles after the raw edge.
- Wrap: RIGHT x4 from POS 0 -> 1,2,3,0. UP from 1 -> 13. DOWN from 13 -> 1.
- Entry: select keys 1,2,3 -> numeros=40'hFFFFFFF123, DIG_COUNT=3. DEL -> 40'hFFFFFFFF12, DIG_COUNT=2. Eleven digit-7 selects after CLR -> numeros=40'h7777777777, DIG_COUNT=10, 11th ignored.
- Operator: buffer 12, select key 10 -> CMD_VALID high exactly 1 cycle, CMD=0, numeros unchanged. Next digit 5 -> numeros=40'hFFFFFFFFF5, DIG_COUNT=1. DEL immediately after the operator -> no change.
- Simultaneous debounced SEL and UP pulses at POS 2 -> digit 2 entered, POS stays 2. Assert RESET mid-debounce -> all outputs return to reset values immediately and asynchronously, and no action follows the release.
